// File: rtl/anabellek_pkg.sv
// Shared types and defaults for the iomem main-memory responder.
package anabellek_pkg;

  // Transaction phases: idle, counting down the latency, answering.
  typedef enum logic [1:0] {
    BOSTA = 2'd0,
    BEKLE = 2'd1,
    YANIT = 2'd2
  } durum_t;

  localparam logic [31:0] VARSAYILAN_BASE = 32'h4000_0000;
  localparam logic [31:0] VARSAYILAN_ERR  = 32'hDEAD_BEEF;

  // Latency is configured at elaboration; the counter must hold LAT_MAX-1.
  localparam int LAT_MIN = 1;
  localparam int LAT_MAX = 15;
  localparam int SAYAC_W = 4;

endpackage

// File: rtl/anabellek_if.sv
// iomem request/response bus between the memory controller and the responder.
interface anabellek_if;
  logic        valid;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ready;
  logic [31:0] rdata;

  modport master (output valid, wstrb, addr, wdata, input  ready, rdata);
  modport slave  (input  valid, wstrb, addr, wdata, output ready, rdata);
endinterface

// File: rtl/anabellek_dizi.sv
// DEPTH x 32 single-port RAM, byte-enable writes, registered read.
module anabellek_dizi #(
  parameter int    ADDR_W    = 14,
  parameter string INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              we,
  input  logic [3:0]        be,
  input  logic [ADDR_W-1:0] idx,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [31:0] mem [DEPTH];

  // Byte-lane writes and a read register (read-before-write on the same edge).
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (we && be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
    end
    rdata <= mem[idx];
  end

endmodule

// File: rtl/anabellek_yanitlayici.sv
// iomem responder: latches one request, waits LATENCY cycles, pulses ready.
module anabellek_yanitlayici
  import anabellek_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = VARSAYILAN_BASE,
  parameter int          ADDR_W    = 14,
  parameter int          LATENCY   = 2,   // LAT_MIN..LAT_MAX
  parameter string       INIT_FILE = "",
  parameter logic [31:0] ERR_DATA  = VARSAYILAN_ERR
) (
  input  logic        clk_i,
  input  logic        rst_i,
  anabellek_if.slave  iomem,
  output logic        hata_o
);

  durum_t              durum, durum_n;
  logic [SAYAC_W-1:0]  sayac;
  logic [ADDR_W-1:0]   idx_q;
  logic [31:0]         wdata_q;
  logic [3:0]          wstrb_q;
  logic                aralik_q;
  logic                hata_q;

  logic [31:0]         ofset;
  logic                aralik;
  logic [ADDR_W-1:0]   ram_idx;
  logic                ram_we;
  logic [31:0]         ram_q;

  // Below-base addresses wrap to huge offsets and fall out of range.
  assign ofset  = iomem.addr - BASE_ADDR;
  assign aralik = (ofset >> (ADDR_W + 2)) == 32'd0;

  // Idle uses the live address so a LATENCY=1 read is ready one cycle later.
  assign ram_idx = (durum == BOSTA) ? ofset[ADDR_W+1:2] : idx_q;
  assign ram_we  = (durum == YANIT) && (wstrb_q != 4'b0000) && aralik_q && !rst_i;

  anabellek_dizi #(.ADDR_W(ADDR_W), .INIT_FILE(INIT_FILE)) u_dizi (
    .clk   (clk_i),
    .we    (ram_we),
    .be    (wstrb_q),
    .idx   (ram_idx),
    .wdata (wdata_q),
    .rdata (ram_q)
  );

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) durum <= BOSTA;
    else       durum <= durum_n;
  end

  // Next state: accept, count down (or abort on dropped valid), answer once.
  always_comb begin
    durum_n = durum;
    case (durum)
      BOSTA: if (iomem.valid) durum_n = (LATENCY == 1) ? YANIT : BEKLE;
      BEKLE: begin
        if (!iomem.valid)           durum_n = BOSTA;
        else if (sayac == SAYAC_W'(1)) durum_n = YANIT;
      end
      YANIT:   durum_n = BOSTA;
      default: durum_n = BOSTA;
    endcase
  end

  // Request latch, latency counter and sticky out-of-range flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sayac    <= '0;
      idx_q    <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      aralik_q <= 1'b0;
      hata_q   <= 1'b0;
    end else begin
      case (durum)
        BOSTA: if (iomem.valid) begin
          idx_q    <= ofset[ADDR_W+1:2];
          wdata_q  <= iomem.wdata;
          wstrb_q  <= iomem.wstrb;
          aralik_q <= aralik;
          sayac    <= SAYAC_W'(LATENCY - 1);
        end
        BEKLE:   sayac <= iomem.valid ? sayac - SAYAC_W'(1) : '0;
        YANIT:   if (!aralik_q) hata_q <= 1'b1;
        default: sayac <= '0;
      endcase
    end
  end

  assign iomem.ready = (durum == YANIT);
  assign iomem.rdata = (durum != YANIT || wstrb_q != 4'b0000) ? 32'd0 :
                       (aralik_q ? ram_q : ERR_DATA);
  assign hata_o      = hata_q;

endmodule

// File: tb/tb_anabellek_yanitlayici.sv
// Self-checking bench for the iomem responder with a byte-level memory model.
module tb_anabellek_yanitlayici;

  localparam logic [31:0] BASE   = 32'h4000_0000;
  localparam int          ADDR_W = 14;
  localparam int          DEPTH  = 1 << ADDR_W;
  localparam logic [31:0] SPAN   = 32'(4 * DEPTH);
  localparam int          LAT    = 2;
  localparam logic [31:0] ERRW   = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic hata;
  anabellek_if bus();

  int vectors = 0;
  int miscompares = 0;

  // Reference memory: byte address (word index * 4 + lane) -> byte.
  logic [7:0] mb [int];

  always #5 clk = ~clk;

  anabellek_yanitlayici #(.BASE_ADDR(BASE), .ADDR_W(ADDR_W), .LATENCY(LAT),
                          .INIT_FILE(""), .ERR_DATA(ERRW)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .iomem (bus.slave),
    .hata_o(hata)
  );

  // Called at posedge+1; returns at posedge+1 after the ready edge, valid dropped.
  task automatic xfer(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      output logic [31:0] rd, output int lat);
    bus.valid = 1'b1; bus.addr = a; bus.wdata = d; bus.wstrb = s;
    rd = 32'd0; lat = -1;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (bus.ready) begin lat = c; rd = bus.rdata; break; end
    end
    @(posedge clk); #1;
    bus.valid = 1'b0;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    bus.valid = 1'b0; bus.addr = '0; bus.wdata = '0; bus.wstrb = '0;
    do_reset(3);
    @(negedge clk);
    vectors++; if (bus.ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready got=%b exp=0", bus.ready); end
    vectors++; if (bus.rdata !== 32'd0) begin miscompares++; $display("FAIL reset_rdata got=%h exp=0", bus.rdata); end
    vectors++; if (hata !== 1'b0) begin miscompares++; $display("FAIL reset_hata got=%b exp=0", hata); end
    @(posedge clk); #1;
  endtask

  task automatic test_write_read();
    logic [31:0] rd; int lat;
    xfer(BASE + 32'h10, 32'h1234_5678, 4'hF, rd, lat);
    vectors++; if (lat != LAT) begin miscompares++; $display("FAIL wr_latency got=%0d exp=%0d", lat, LAT); end
    vectors++; if (rd !== 32'd0) begin miscompares++; $display("FAIL wr_rdata got=%h exp=0", rd); end
    xfer(BASE + 32'h10, 32'h0, 4'h0, rd, lat);
    vectors++; if (lat != LAT) begin miscompares++; $display("FAIL rd_latency got=%0d exp=%0d", lat, LAT); end
    vectors++; if (rd !== 32'h1234_5678) begin miscompares++; $display("FAIL rd_data got=%h exp=12345678", rd); end
  endtask

  task automatic test_strobes();
    logic [31:0] rd; int lat;
    xfer(BASE + 32'h14, 32'hAABB_CCDD, 4'hF, rd, lat);
    xfer(BASE + 32'h14, 32'h1122_3344, 4'b0101, rd, lat);
    xfer(BASE + 32'h14, 32'h0, 4'h0, rd, lat);
    vectors++; if (rd !== 32'hAA22_CC44) begin miscompares++; $display("FAIL strobe_merge got=%h exp=aa22cc44", rd); end
  endtask

  // Four reads with valid held high; address advances right after each ready.
  task automatic test_back_to_back();
    logic [31:0] rd; int lat; int p;
    logic [31:0] line [4];
    for (int i = 0; i < 4; i++) begin
      line[i] = $urandom;
      xfer(BASE + 32'h20 + 32'(4*i), line[i], 4'hF, rd, lat);
    end
    p = 0;
    bus.valid = 1'b1; bus.addr = BASE + 32'h20; bus.wstrb = 4'h0; bus.wdata = '0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (bus.ready) begin
        if (p < 4) begin
          vectors++; if (bus.rdata !== line[p]) begin miscompares++; $display("FAIL fill_data%0d got=%h exp=%h", p, bus.rdata, line[p]); end
          vectors++; if (c != 2 + 3*p) begin miscompares++; $display("FAIL fill_cycle%0d got=%0d exp=%0d", p, c, 2 + 3*p); end
        end
        p++;
        @(posedge clk); #1;
        if (p < 4) bus.addr = BASE + 32'h20 + 32'(4*p);
        else       bus.valid = 1'b0;
      end
    end
    vectors++; if (p != 4) begin miscompares++; $display("FAIL fill_pulses got=%0d exp=4", p); end
    @(posedge clk); #1;
  endtask

  task automatic test_out_of_range();
    logic [31:0] rd; int lat;
    xfer(BASE, 32'h0101_0101, 4'hF, rd, lat);
    xfer(BASE + SPAN - 4, 32'h0202_0202, 4'hF, rd, lat);
    vectors++; if (hata !== 1'b0) begin miscompares++; $display("FAIL oor_hata_pre got=%b exp=0", hata); end
    xfer(BASE - 4, 32'h0, 4'h0, rd, lat);
    vectors++; if (lat != LAT) begin miscompares++; $display("FAIL oor_lo_latency got=%0d exp=%0d", lat, LAT); end
    vectors++; if (rd !== ERRW) begin miscompares++; $display("FAIL oor_lo_rdata got=%h exp=%h", rd, ERRW); end
    vectors++; if (hata !== 1'b1) begin miscompares++; $display("FAIL oor_lo_hata got=%b exp=1", hata); end
    do_reset(1);
    xfer(BASE + SPAN, 32'h0, 4'h0, rd, lat);
    vectors++; if (lat != LAT) begin miscompares++; $display("FAIL oor_hi_latency got=%0d exp=%0d", lat, LAT); end
    vectors++; if (rd !== ERRW) begin miscompares++; $display("FAIL oor_hi_rdata got=%h exp=%h", rd, ERRW); end
    vectors++; if (hata !== 1'b1) begin miscompares++; $display("FAIL oor_hi_hata got=%b exp=1", hata); end
    xfer(BASE - 4, 32'hFFFF_FFFF, 4'hF, rd, lat);
    xfer(BASE + SPAN, 32'hFFFF_FFFF, 4'hF, rd, lat);
    xfer(BASE, 32'h0, 4'h0, rd, lat);
    vectors++; if (rd !== 32'h0101_0101) begin miscompares++; $display("FAIL oor_keep_first got=%h exp=01010101", rd); end
    xfer(BASE + SPAN - 4, 32'h0, 4'h0, rd, lat);
    vectors++; if (rd !== 32'h0202_0202) begin miscompares++; $display("FAIL oor_keep_last got=%h exp=02020202", rd); end
  endtask

  task automatic test_abort();
    logic [31:0] rd; int lat; int pulses;
    xfer(BASE + 32'h30, 32'h0BAD_F00D, 4'hF, rd, lat);
    bus.valid = 1'b1; bus.addr = BASE + 32'h30; bus.wdata = 32'hFFFF_FFFF; bus.wstrb = 4'hF;
    @(posedge clk); #1;
    bus.valid = 1'b0;
    pulses = 0;
    repeat (5) begin @(negedge clk); if (bus.ready) pulses++; end
    vectors++; if (pulses != 0) begin miscompares++; $display("FAIL abort_ready got=%0d exp=0", pulses); end
    @(posedge clk); #1;
    xfer(BASE + 32'h30, 32'h0, 4'h0, rd, lat);
    vectors++; if (lat != LAT) begin miscompares++; $display("FAIL abort_next_latency got=%0d exp=%0d", lat, LAT); end
    vectors++; if (rd !== 32'h0BAD_F00D) begin miscompares++; $display("FAIL abort_ram got=%h exp=0badf00d", rd); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; int lat;
    xfer(BASE + 32'h34, 32'h5555_AAAA, 4'hF, rd, lat);
    xfer(BASE - 32'h100, 32'h0, 4'h0, rd, lat);
    bus.valid = 1'b1; bus.addr = BASE + 32'h34; bus.wdata = 32'hFFFF_FFFF; bus.wstrb = 4'hF;
    @(posedge clk); #1;
    rst = 1'b1; bus.valid = 1'b0;
    @(negedge clk);
    vectors++; if (bus.ready !== 1'b0) begin miscompares++; $display("FAIL rstmid_ready_c1 got=%b exp=0", bus.ready); end
    @(negedge clk);
    vectors++; if (bus.ready !== 1'b0) begin miscompares++; $display("FAIL rstmid_ready got=%b exp=0", bus.ready); end
    vectors++; if (bus.rdata !== 32'd0) begin miscompares++; $display("FAIL rstmid_rdata got=%h exp=0", bus.rdata); end
    vectors++; if (hata !== 1'b0) begin miscompares++; $display("FAIL rstmid_hata got=%b exp=0", hata); end
    @(posedge clk); #1 rst = 1'b0;
    xfer(BASE + 32'h34, 32'h0, 4'h0, rd, lat);
    vectors++; if (rd !== 32'h5555_AAAA) begin miscompares++; $display("FAIL rstmid_ram got=%h exp=5555aaaa", rd); end
  endtask

  // Random mix against the byte model; hata expectation accumulates from reset.
  task automatic test_random();
    logic [31:0] rd, a, d, off, exp; logic [3:0] s; int lat, key; bit inr, exp_hata, known;
    do_reset(1);
    exp_hata = 1'b0;
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 9))
        0:       a = BASE - 32'(4 * $urandom_range(1, 4));
        1:       a = BASE + SPAN + 32'(4 * $urandom_range(0, 3));
        default: a = BASE + 32'h100 + 32'(4 * $urandom_range(0, 7));
      endcase
      a[1:0] = 2'($urandom);
      d = $urandom;
      s = (i < 8 || $urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
      if (i < 8) begin a = BASE + 32'h100 + 32'(4*i); s = 4'hF; end
      off = a - BASE;
      inr = off < SPAN;
      key = int'(off >> 2) * 4;
      known = 1'b1;
      exp = 32'd0;
      if (s != 4'h0) begin
        if (inr) for (int b = 0; b < 4; b++) if (s[b]) mb[key + b] = d[8*b +: 8];
      end else if (!inr) begin
        exp = ERRW;
      end else begin
        for (int b = 0; b < 4; b++) begin
          if (mb.exists(key + b)) exp[8*b +: 8] = mb[key + b];
          else known = 1'b0;
        end
      end
      if (!inr) exp_hata = 1'b1;
      xfer(a, d, s, rd, lat);
      vectors++; if (lat != LAT) begin miscompares++; $display("FAIL rnd%0d_latency got=%0d exp=%0d", i, lat, LAT); end
      if (known) begin
        vectors++; if (rd !== exp) begin miscompares++; $display("FAIL rnd%0d_rdata a=%h s=%h got=%h exp=%h", i, a, s, rd, exp); end
      end
      vectors++; if (hata !== exp_hata) begin miscompares++; $display("FAIL rnd%0d_hata got=%b exp=%b", i, hata, exp_hata); end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_strobes();
    test_back_to_back();
    test_out_of_range();
    test_abort();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
